// File: rtl/upcount_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : upcount_ctrl
//  Description : Run controller for an external N-bit up-counter. A run is
//                requested with i_start in IDLE. The controller then loads
//                the counter with the captured start value and enables it
//                until the counter value i_q equals the captured end value.
//                After that it raises a one-cycle o_done pulse. i_abort ends
//                a run without o_done. i_pause freezes counting.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                i_start, i_abort    - run request / run termination
//                i_pause             - hold the counter while running
//                i_start_val         - first count value (N bits)
//                i_end_val           - terminal count value (N bits)
//                i_q                 - present counter value (N bits)
//                o_r                 - counter parallel-load value (N bits)
//                o_l, o_e            - counter load strobe / count enable
//                o_busy, o_done      - run in progress / completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module upcount_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic         i_pause,
    input  logic [N-1:0] i_start_val,
    input  logic [N-1:0] i_end_val,
    input  logic [N-1:0] i_q,
    output logic [N-1:0] o_r,
    output logic         o_l,
    output logic         o_e,
    output logic         o_busy,
    output logic         o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [N-1:0] r_start;
    logic [N-1:0] r_end;
    logic         w_accept;
    logic         w_at_end;

    // Abort wins over a simultaneous start, so nothing is captured then.
    assign w_accept = (r_state == S_IDLE) && i_start && !i_abort;
    assign w_at_end = (i_q == r_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_start <= '0;
            r_end   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_start <= i_start_val;
                r_end   <= i_end_val;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        o_l    = 1'b0;
        o_e    = 1'b0;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                o_busy = 1'b1;
                o_l    = !i_abort;
                w_next = i_abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (w_at_end) begin
                    // Terminal value reached: finish regardless of pause.
                    w_next = S_DONE;
                end else begin
                    o_e = !i_pause;
                end
            end
            S_DONE: begin
                // Abort is deliberately ignored here; the pulse always fires.
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign o_r = r_start;

endmodule
`default_nettype wire

// File: tb/tb_upcount_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_upcount_ctrl
//  Description : Testbench for upcount_ctrl with an attached up-counter,
//                directed run scenarios and randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_upcount_ctrl;

    localparam int N = 4;
    localparam int c_mod = 1 << N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, abort, pause;
    logic [N-1:0] start_val, end_val;
    logic [N-1:0] q = '0;
    logic [N-1:0] r;
    logic         l, e, busy, done;

    int checks = 0;
    int errors = 0;

    // Reference run model: whether a run is active, how many cycles it has
    // lasted, and whether the completion cycle is due.
    bit       m_active = 0;
    int       m_age    = 0;
    bit       m_done   = 0;
    bit [N-1:0] m_s = '0;
    bit [N-1:0] m_e = '0;
    int       obs_e_cnt, obs_busy_cnt, pause_cnt;

    upcount_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .i_abort    (abort),
        .i_pause    (pause),
        .i_start_val(start_val),
        .i_end_val  (end_val),
        .i_q        (q),
        .o_r        (r),
        .o_l        (l),
        .o_e        (e),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    // The controlled counter: loads through l, counts through e, wraps mod 2^N.
    always @(posedge clk) begin
        if (l)      q <= r;
        else if (e) q <= q + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare one cycle's outputs with the model, then advance the model for
    // the coming rising edge. Inputs must already be set by the caller.
    task automatic step();
        bit exp_l, exp_e, exp_busy, exp_done;
        int len;
        #1;
        exp_l = 0; exp_e = 0; exp_busy = 0; exp_done = 0;
        if (m_done) begin
            exp_done = 1;
        end else if (m_active) begin
            exp_busy = 1;
            if (m_age == 0) exp_l = !abort;
            else            exp_e = !abort && !pause && (q != m_e);
        end
        check("r", r, m_s);
        check("l", l, exp_l);
        check("e", e, exp_e);
        check("busy", busy, exp_busy);
        check("done", done, exp_done);

        if (m_active) begin
            obs_busy_cnt += busy;
            obs_e_cnt    += e;
            if (m_age > 0 && pause && !abort && q != m_e) pause_cnt++;
        end

        if (rst) begin
            m_active = 0; m_done = 0; m_s = '0; m_e = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (abort) begin
                m_active = 0;
            end else if (m_age > 0 && q == m_e) begin
                // Run completes: length follows from modular distance alone.
                len = (int'(m_e) - int'(m_s) + c_mod) % c_mod;
                check("run_e_cycles", obs_e_cnt, len);
                check("run_busy_cycles", obs_busy_cnt, 2 + len + pause_cnt);
                check("q_at_end", q, m_e);
                m_active = 0;
                m_done   = 1;
            end else begin
                m_age++;
            end
        end else if (start && !abort) begin
            m_s = start_val; m_e = end_val;
            m_active = 1; m_age = 0;
            obs_e_cnt = 0; obs_busy_cnt = 0; pause_cnt = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; start = 0; abort = 0; pause = 0;
        start_val = N'($urandom); end_val = N'($urandom);
    endtask

    // One run from IDLE. pause_q/abort_q/rst_q select the counter value at
    // which that event happens during RUN (-1 = never).
    task automatic scen(input int sv, input int ev, input int pause_q, input int pause_len,
                        input int abort_q, input int rst_q, input bit spam, input int exp_dones);
        int  pause_left = pause_len;
        bit  pausing = 0, ab_fired = 0, rs_fired = 0, finished = 0;
        int  dones = 0;
        idle_inputs();
        start = 1; start_val = N'(sv); end_val = N'(ev);
        step();
        for (int k = 0; k < 64 && !finished; k++) begin
            idle_inputs();
            if (spam) start = 1'($urandom_range(0, 1));
            if (m_active && m_age > 0) begin
                if (pause_q >= 0 && int'(q) == pause_q && pause_left > 0) pausing = 1;
                if (pausing && pause_left > 0) begin pause = 1; pause_left--; end
                if (abort_q >= 0 && int'(q) == abort_q && !ab_fired) begin abort = 1; ab_fired = 1; end
                if (rst_q >= 0 && int'(q) == rst_q && !rs_fired) begin rst = 1; rs_fired = 1; end
            end
            dones += done;
            step();
            if (!m_active && !m_done) finished = 1;
        end
        check("scen_finished", finished, 1);
        check("scen_done_count", dones, exp_dones);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        step();
        rst = 0;
        check("reset_r", r, 0);
        check("reset_busy", busy, 0);

        scen(1, 4, -1, 0, -1, -1, 0, 1);
        check("s1_q", q, 4);
        scen(14, 2, -1, 0, -1, -1, 0, 1);
        check("s2_q", q, 2);
        scen(5, 5, -1, 0, -1, -1, 0, 1);
        check("s3_q", q, 5);
        scen(0, 6, 3, 3, -1, -1, 1, 1);
        check("s4_q", q, 6);
        scen(0, 9, -1, 0, 4, -1, 0, 0);
        check("s5_q", q, 4);

        // Start together with abort in IDLE: nothing captured, stays idle.
        idle_inputs();
        start = 1; abort = 1; start_val = 4'd11; end_val = 4'd12;
        step();
        idle_inputs();
        step();
        check("start_abort_r", r, 0);

        scen(0, 9, -1, 0, -1, 3, 0, 0);
        check("s6_r", r, 0);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            idle_inputs();
            start = ($urandom_range(0, 9) < 3);
            abort = ($urandom_range(0, 39) == 0);
            pause = ($urandom_range(0, 4) == 0);
            rst   = ($urandom_range(0, 99) < 2);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
